jpeg_byte_stuffer: RTL

JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

---
 rtl/jpeg_byte_stuffer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/jpeg_byte_stuffer.sv
// JPEG entropy-stream byte stuffer: buffers 32-bit words and emits bytes MSB first with 0x00 after every 0xFF.
// Optional feature macro: JPEG_STUFFER_EOI_EN appends the FF D9 end-of-image marker.
module jpeg_byte_stuffer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_en,
  input  logic [31:0] I_stream,
  input  logic        I_stream_valid,
  input  logic        I_end_of_img,
  input  logic        I_ready,
  output logic [7:0]  O_byte,
  output logic        O_byte_valid,
  output logic        O_overflow,
  output logic        O_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    STUFF,
`ifdef JPEG_STUFFER_EOI_EN
    EOI_FF,
    EOI_D9,
`endif
    DONE
  } state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   head;
  logic [31:0]   shreg;
  logic [1:0]    cnt;
  logic          eoi_pend;
  logic          full;
  logic          empty;
  logic          xfer;
  logic          word_end;
  logic          pop;
  logic          push;

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign xfer  = O_byte_valid && I_ready;

  // The last data byte (or its trailing stuff byte) being accepted frees the shift register.
  always_comb begin
    word_end = 1'b0;
    if (xfer && cnt == 2'd3) begin
      if (state == STUFF)
        word_end = 1'b1;
      else if (state == SEND && O_byte != 8'hFF)
        word_end = 1'b1;
    end
  end

  assign pop  = I_en && ((state == LOAD) || (word_end && !empty));
  assign push = I_en && I_stream_valid && (!full || pop);

  always_ff @(posedge I_clk) begin
    if (push)
      mem[wr_ptr] <= I_stream;
  end

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      O_overflow <= 1'b0;
    end else if (I_en) begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (!push && pop)
        count <= count - (AW+1)'(1);
      if (I_stream_valid && !push)
        O_overflow <= 1'b1;
    end
  end

  // A word finishing with more words queued reloads on the same edge, so the stream has no bubble.
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      eoi_pend     <= 1'b0;
      O_byte       <= '0;
      O_byte_valid <= 1'b0;
      O_done       <= 1'b0;
    end else if (I_en) begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state <= LOAD;
          end else if (eoi_pend) begin
`ifdef JPEG_STUFFER_EOI_EN
            state        <= EOI_FF;
            O_byte       <= 8'hFF;
            O_byte_valid <= 1'b1;
`else
            state    <= DONE;
            O_done   <= 1'b1;
            eoi_pend <= 1'b0;
`endif
          end
        end
        LOAD: begin
          shreg        <= head;
          cnt          <= 2'd0;
          O_byte       <= head[31:24];
          O_byte_valid <= 1'b1;
          state        <= SEND;
        end
        SEND, STUFF: begin
          if (xfer) begin
            if (state == SEND && O_byte == 8'hFF) begin
              state  <= STUFF;
              O_byte <= 8'h00;
            end else if (cnt != 2'd3) begin
              cnt    <= cnt + 2'd1;
              O_byte <= pick(shreg, cnt + 2'd1);
              state  <= SEND;
            end else if (!empty) begin
              shreg  <= head;
              cnt    <= 2'd0;
              O_byte <= head[31:24];
              state  <= SEND;
            end else if (eoi_pend) begin
`ifdef JPEG_STUFFER_EOI_EN
              state  <= EOI_FF;
              O_byte <= 8'hFF;
`else
              state        <= DONE;
              O_byte       <= 8'h00;
              O_byte_valid <= 1'b0;
              O_done       <= 1'b1;
              eoi_pend     <= 1'b0;
`endif
            end else begin
              state        <= IDLE;
              O_byte       <= 8'h00;
              O_byte_valid <= 1'b0;
            end
          end
        end
`ifdef JPEG_STUFFER_EOI_EN
        EOI_FF: begin
          if (xfer) begin
            O_byte <= 8'hD9;
            state  <= EOI_D9;
          end
        end
        EOI_D9: begin
          if (xfer) begin
            O_byte       <= 8'h00;
            O_byte_valid <= 1'b0;
            O_done       <= 1'b1;
            eoi_pend     <= 1'b0;
            state        <= DONE;
          end
        end
`endif
        DONE: begin
          O_done <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // A new end-of-image pulse wins over the clear from a marker finishing on the same edge.
      if (I_end_of_img)
        eoi_pend <= 1'b1;
    end
  end

endmodule
